// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD measurement path: state encoding and
// accumulator sizing used by adc_accum.
package spgd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } acc_state_e;

  localparam int ADC_WIDTH_DEF    = 14;
  localparam int LOG2_SAMPLES_DEF = 10;
  localparam int ACC_WIDTH_DEF    = ADC_WIDTH_DEF + LOG2_SAMPLES_DEF;

  // Sum of 2^log2_samples samples of adc_width bits can never overflow this.
  function automatic int acc_width(int adc_width, int log2_samples);
    return adc_width + log2_samples;
  endfunction

endpackage

// File: rtl/adc_clip_detect.sv
// Combinational full-scale detector for a two's complement ADC sample.
// Only built when ADC_ACC_OVR_EN is defined (the clip flag in adc_accum).
`ifdef ADC_ACC_OVR_EN
module adc_clip_detect #(
  parameter int ADC_WIDTH = 14
) (
  input  logic [ADC_WIDTH-1:0] sample_i,
  output logic                 clip_o
);

  localparam logic [ADC_WIDTH-1:0] CODE_MAX = {1'b0, {(ADC_WIDTH-1){1'b1}}};
  localparam logic [ADC_WIDTH-1:0] CODE_MIN = {1'b1, {(ADC_WIDTH-1){1'b0}}};

  assign clip_o = (sample_i == CODE_MAX) || (sample_i == CODE_MIN);

endmodule
`endif

// File: rtl/adc_accum.sv
// Window accumulator: skips settling samples, sums 2^LOG2_SAMPLES samples and
// presents the floor mean on J_OUT. ADC_ACC_OVR_EN adds the OVR clip output.
//
// state | meaning
// IDLE  | waiting for ADC_EN, accumulator and counter at 0
// SKIP  | discarding SKIP_CYCLES settling samples
// ACC   | summing samples, counter tracks remaining adds
// DONE  | window complete, wait for ADC_EN low
module adc_accum
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
  parameter int LOG2_SAMPLES = LOG2_SAMPLES_DEF,
  parameter int SKIP_CYCLES  = 2
) (
  input  logic                 ADC_CLK,
  input  logic                 RST,
  input  logic                 ADC_EN,
  input  logic [ADC_WIDTH-1:0] ADC_DATA,
  output logic                 ADC_DONE,
  output logic [ADC_WIDTH-1:0] J_OUT,
  output logic                 ACC_BUSY
`ifdef ADC_ACC_OVR_EN
  ,
  output logic                 OVR
`endif
);

  localparam int ACC_W  = acc_width(ADC_WIDTH, LOG2_SAMPLES);
  localparam int SKIP_W = $clog2(SKIP_CYCLES + 1);
  localparam int CNT_W  = ((LOG2_SAMPLES > SKIP_W) ? LOG2_SAMPLES : SKIP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_ACC  = CNT_W'((1 << LOG2_SAMPLES) - 1);
  localparam logic [CNT_W-1:0] CNT_SKIP = CNT_W'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  acc_state_e state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sample_ext, acc_sum;
  logic [ADC_WIDTH-1:0]    j_q, j_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  assign sample_ext = {{LOG2_SAMPLES{ADC_DATA[ADC_WIDTH-1]}}, ADC_DATA};
  assign acc_sum    = acc_q + sample_ext;

`ifdef ADC_ACC_OVR_EN
  logic clip_now;
  logic clip_q, clip_d;
  logic ovr_q, ovr_d;

  adc_clip_detect #(.ADC_WIDTH(ADC_WIDTH)) u_clip (
    .sample_i (ADC_DATA),
    .clip_o   (clip_now)
  );
`endif

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ADC_EN) state_d = (SKIP_CYCLES == 0) ? ACC : SKIP;
      SKIP: begin
        if (!ADC_EN)         state_d = IDLE;
        else if (cnt_q == 0) state_d = ACC;
      end
      ACC: begin
        if (!ADC_EN)         state_d = IDLE;
        else if (cnt_q == 0) state_d = DONE;
      end
      DONE:    if (!ADC_EN) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    acc_d  = '0;
    j_d    = j_q;
    done_d = 1'b0;
    busy_d = (state_d == SKIP) || (state_d == ACC);
`ifdef ADC_ACC_OVR_EN
    clip_d = clip_q;
    ovr_d  = ovr_q;
`endif
    case (state_q)
      IDLE: begin
        if (ADC_EN) cnt_d = (SKIP_CYCLES == 0) ? CNT_ACC : CNT_SKIP;
`ifdef ADC_ACC_OVR_EN
        clip_d = 1'b0;
`endif
      end
      SKIP: begin
        if (ADC_EN) cnt_d = (cnt_q == 0) ? CNT_ACC : cnt_q - CNT_ONE;
      end
      ACC: begin
        if (ADC_EN) begin
`ifdef ADC_ACC_OVR_EN
          clip_d = clip_q | clip_now;
`endif
          if (cnt_q == 0) begin
            // Upper slice of the signed sum is the arithmetic shift (floor mean).
            j_d    = acc_sum[ACC_W-1:LOG2_SAMPLES];
            done_d = 1'b1;
`ifdef ADC_ACC_OVR_EN
            ovr_d  = clip_q | clip_now;
`endif
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      j_q    <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      j_q    <= j_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

`ifdef ADC_ACC_OVR_EN
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      clip_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      clip_q <= clip_d;
      ovr_q  <= ovr_d;
    end
  end

  assign OVR = ovr_q;
`endif

  assign ADC_DONE = done_q;
  assign J_OUT    = j_q;
  assign ACC_BUSY = busy_q;

endmodule

// File: tb/tb_adc_accum.sv
// Directed bench for adc_accum: default window, floor rounding, short windows,
// abort/re-trigger, async reset and (with ADC_ACC_OVR_EN) the clip flag.
module tb_adc_accum;

  localparam logic signed [13:0] MAXC = 14'sh1FFF;
  localparam logic signed [13:0] MINC = 14'sh2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               en = 1'b0;
  logic signed [13:0] data = '0;
  logic               done, busy;
  logic [13:0]        j;

  logic               en_s = 1'b0;
  logic signed [13:0] data_s = '0;
  logic               done2, busy2, done0, busy0;
  logic [13:0]        j2, j0;

`ifdef ADC_ACC_OVR_EN
  logic ovr, ovr2, ovr0;
`endif

  adc_accum u_dut (
    .ADC_CLK (clk), .RST (rst), .ADC_EN (en), .ADC_DATA (data),
    .ADC_DONE (done), .J_OUT (j), .ACC_BUSY (busy)
`ifdef ADC_ACC_OVR_EN
    , .OVR (ovr)
`endif
  );

  adc_accum #(.LOG2_SAMPLES(2), .SKIP_CYCLES(2)) u_s2 (
    .ADC_CLK (clk), .RST (rst), .ADC_EN (en_s), .ADC_DATA (data_s),
    .ADC_DONE (done2), .J_OUT (j2), .ACC_BUSY (busy2)
`ifdef ADC_ACC_OVR_EN
    , .OVR (ovr2)
`endif
  );

  adc_accum #(.LOG2_SAMPLES(2), .SKIP_CYCLES(0)) u_s0 (
    .ADC_CLK (clk), .RST (rst), .ADC_EN (en_s), .ADC_DATA (data_s),
    .ADC_DONE (done0), .J_OUT (j0), .ACC_BUSY (busy0)
`ifdef ADC_ACC_OVR_EN
    , .OVR (ovr0)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n counts edges with the sampling edge as 1, so the default window lands on 1027.
  task automatic wait_done(input int limit, input bit alt, output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    do begin
      tick();
      n++;
      if (busy) nbusy++;
      if (alt) data = (data == MINC) ? MAXC : MINC;
    end while (!done && n < limit);
  endtask

  task automatic restart();
    en = 1'b0;
    tick();
    en = 1'b1;
  endtask

  int n, nb, pulses, lat2, lat0;
  int jv2, jv0;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("rst_j", $signed(j), 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_busy_s2", busy2, 0);
`ifdef ADC_ACC_OVR_EN
    check("rst_ovr", ovr, 0);
    check("rst_ovr_s", ovr2 | ovr0, 0);
`endif
    rst = 1'b0;
    tick();

    // Constant 100, ADC_EN held high
    data = 14'sd100;
    en = 1'b1;
    wait_done(1100, 1'b0, n, nb);
    check("t1_latency", n, 1027);
    check("t1_busy_cycles", nb, 1026);
    check("t1_j", $signed(j), 100);
    tick();
    check("t1_pulse_width", done, 0);
    pulses = 0;
    repeat (50) begin
      tick();
      if (done) pulses++;
    end
    check("t1_no_second_pulse", pulses, 0);
    check("t1_busy_in_done", busy, 0);

    // Alternating full-scale codes: sum -512 floors to -1
    restart();
    data = MINC;
    wait_done(1100, 1'b1, n, nb);
    check("t2_alt_latency", n, 1027);
    check("t2_alt_j", $signed(j), -1);
    restart();
    data = -14'sd1;
    wait_done(1100, 1'b0, n, nb);
    check("t2_neg1_j", $signed(j), -1);

    // Short windows with a ramp, one value per edge after the sampling edge
    en_s = 1'b1;
    tick();
    data_s = '0;
    lat2 = 0; lat0 = 0; jv2 = 0; jv0 = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (done2 && lat2 == 0) begin lat2 = k; jv2 = $signed(j2); end
      if (done0 && lat0 == 0) begin lat0 = k; jv0 = $signed(j0); end
      data_s = data_s + 14'sd1;
    end
    en_s = 1'b0;
    check("t3_skip2_latency", lat2, 7);
    check("t3_skip2_j", jv2, 3);
    check("t3_skip0_latency", lat0, 5);
    check("t3_skip0_j", jv0, 1);

    // Abort mid-ACC keeps J_OUT, then re-trigger after one low edge
    restart();
    data = 14'sd100;
    wait_done(1100, 1'b0, n, nb);
    check("t4_pre_j", $signed(j), 100);
    restart();
    data = -14'sd50;
    tick();
    repeat (2) tick();
    pulses = 0;
    repeat (500) begin
      tick();
      if (done) pulses++;
    end
    check("t4_busy_in_acc", busy, 1);
    en = 1'b0;
    tick();
    check("t4_abort_pulses", pulses + done, 0);
    check("t4_abort_j", $signed(j), 100);
    check("t4_abort_idle", busy, 0);
    en = 1'b1;
    wait_done(1100, 1'b0, n, nb);
    check("t4_retrig_latency", n, 1027);
    check("t4_retrig_j", $signed(j), -50);

    // Asynchronous reset between edges during ACC
    restart();
    repeat (600) tick();
    check("t5_busy_before_rst", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_j", $signed(j), 0);
    check("t5_async_done", done, 0);
    check("t5_async_busy", busy, 0);
    tick();
    rst = 1'b0;
    data = 14'sd100;
    wait_done(1100, 1'b0, n, nb);
    check("t5_fresh_latency", n, 1027);
    check("t5_fresh_j", $signed(j), 100);

`ifdef ADC_ACC_OVR_EN
    // One clipped sample in the accumulated region
    restart();
    data = '0;
    tick();
    repeat (2) tick();
    data = MAXC;
    tick();
    data = '0;
    wait_done(1100, 1'b0, n, nb);
    check("t6_ovr_set", ovr, 1);
    restart();
    wait_done(1100, 1'b0, n, nb);
    check("t6_ovr_clean", ovr, 0);
    // Clipped samples only while skipping
    restart();
    tick();
    data = MAXC;
    repeat (2) tick();
    data = '0;
    wait_done(1100, 1'b0, n, nb);
    check("t6_ovr_skip_only", ovr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
